// File: rtl/riscv_pkg.sv
// Shared RV32I encodings used by the writeback stage: opcodes,
// load funct3 codes and the integer register width.
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/wb_load_align.sv
// Extracts and extends the addressed byte/half/word from a raw aligned
// memory word; valid drops for reserved load funct3 encodings.
module wb_load_align
    import riscv_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic [31:0] raw,
    output logic [31:0] data,
    output logic        valid
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = raw[7:0];
        case (off)
            2'd0: byte_sel = raw[7:0];
            2'd1: byte_sel = raw[15:8];
            2'd2: byte_sel = raw[23:16];
            2'd3: byte_sel = raw[31:24];
            default: byte_sel = raw[7:0];
        endcase
        // Halfword loads select on off[1] only; off[0] is ignored.
        half_sel = off[1] ? raw[31:16] : raw[15:0];
    end

    always_comb begin
        data  = '0;
        valid = 1'b1;
        case (funct3)
            F3_LB:   data = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU:  data = {24'd0, byte_sel};
            F3_LH:   data = {{16{half_sel[15]}}, half_sel};
            F3_LHU:  data = {16'd0, half_sel};
            F3_LW:   data = raw;
            default: valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/wb_regfile_unit.sv
// Writeback stage: selects the rd value for the WB instruction, owns the
// x1..x31 register file with write-through bypass, and counts retirements.
module wb_regfile_unit
    import riscv_pkg::*;
#(
    parameter int ADDR_WIDTH = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic [ADDR_WIDTH-1:0] wb_pc_plus4,
    input  logic [31:0]           wb_inst,
    input  logic [31:0]           wb_alu_out,
    input  logic [31:0]           wb_ld_data,
    input  logic [4:0]            rs1_addr,
    input  logic [4:0]            rs2_addr,
    output logic [31:0]           rs1_data,
    output logic [31:0]           rs2_data,
    output logic                  wb_we,
    output logic [4:0]            wb_rd,
    output logic [31:0]           wb_data,
    output logic [63:0]           instret
);

    logic [6:0]      opcode;
    logic [XLEN-1:0] ld_data;
    logic            ld_valid;
    logic            writes_rd;
    logic [XLEN-1:0] regs [1:31];
    logic            unused_inst_hi;

    assign opcode         = wb_inst[6:0];
    assign wb_rd          = wb_inst[11:7];
    assign unused_inst_hi = ^wb_inst[31:15];

    wb_load_align u_load_align (
        .funct3 (wb_inst[14:12]),
        .off    (wb_alu_out[1:0]),
        .raw    (wb_ld_data),
        .data   (ld_data),
        .valid  (ld_valid)
    );

    always_comb begin
        wb_data   = '0;
        writes_rd = 1'b0;
        case (opcode)
            OPC_LOAD: begin
                writes_rd = ld_valid;
                wb_data   = ld_valid ? ld_data : '0;
            end
            OPC_JAL, OPC_JALR: begin
                writes_rd = 1'b1;
                wb_data   = XLEN'(wb_pc_plus4);
            end
            OPC_OP, OPC_OPIMM, OPC_LUI, OPC_AUIPC: begin
                writes_rd = 1'b1;
                wb_data   = wb_alu_out;
            end
            default: ;
        endcase
    end

    assign wb_we = writes_rd && (wb_rd != 5'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 1; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_we && !stall) begin
            regs[wb_rd] <= wb_data;
        end
    end

    // Bypass stays active during stall so ID sees the pending value.
    assign rs1_data = (rs1_addr == 5'd0)               ? '0      :
                      (wb_we && (wb_rd == rs1_addr))    ? wb_data : regs[rs1_addr];
    assign rs2_data = (rs2_addr == 5'd0)               ? '0      :
                      (wb_we && (wb_rd == rs2_addr))    ? wb_data : regs[rs2_addr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instret <= '0;
        end else if (!stall && (wb_inst != '0)) begin
            instret <= instret + 64'd1;
        end
    end

endmodule

// File: tb/tb_wb_regfile_unit.sv
// Self-checking bench for wb_regfile_unit: directed scenarios followed by
// randomized instruction streams checked against a register-array model.
module tb_wb_regfile_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic [14:0] wb_pc_plus4;
    logic [31:0] wb_inst;
    logic [31:0] wb_alu_out;
    logic [31:0] wb_ld_data;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [63:0] instret;

    int checks = 0;
    int errors = 0;

    logic [31:0] mregs [32];
    logic [63:0] minstret;

    always #5 clk = ~clk;

    wb_regfile_unit #(.ADDR_WIDTH(15)) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .wb_pc_plus4 (wb_pc_plus4),
        .wb_inst     (wb_inst),
        .wb_alu_out  (wb_alu_out),
        .wb_ld_data  (wb_ld_data),
        .rs1_addr    (rs1_addr),
        .rs2_addr    (rs2_addr),
        .rs1_data    (rs1_data),
        .rs2_data    (rs2_data),
        .wb_we       (wb_we),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .instret     (instret)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference writeback computed from the instruction set rules.
    function automatic void ref_wb(input logic [31:0] inst, input logic [31:0] alu,
                                   input logic [31:0] ld, input logic [14:0] pc,
                                   output logic we, output logic [31:0] data,
                                   output logic known);
        int unsigned opc, f3, rd, off, v;
        bit writes;
        opc = inst & 32'h7F;
        f3  = (inst >> 12) & 7;
        rd  = (inst >> 7) & 31;
        off = alu % 4;
        writes = 1'b0;
        known  = 1'b1;
        data   = 32'd0;
        if (opc == 'h03) begin
            writes = 1'b1;
            if (f3 == 0 || f3 == 4) begin
                v = (ld >> (8 * off)) & 255;
                data = (f3 == 0 && v >= 128) ? v + 32'hFFFF_FF00 : v;
            end else if (f3 == 1 || f3 == 5) begin
                v = (ld >> (16 * (off / 2))) & 65535;
                data = (f3 == 1 && v >= 32768) ? v + 32'hFFFF_0000 : v;
            end else if (f3 == 2) begin
                data = ld;
            end else begin
                writes = 1'b0;
                known  = 1'b0;
            end
        end else if (opc == 'h6F || opc == 'h67) begin
            writes = 1'b1;
            data   = {17'd0, pc};
        end else if (opc == 'h33 || opc == 'h13 || opc == 'h37 || opc == 'h17) begin
            writes = 1'b1;
            data   = alu;
        end
        we = writes && (rd != 0);
    endfunction

    task automatic apply(input logic [31:0] inst, input logic [31:0] alu, input logic [31:0] ld,
                         input logic [14:0] pc, input logic st, input logic [4:0] a1,
                         input logic [4:0] a2);
        wb_inst     = inst;
        wb_alu_out  = alu;
        wb_ld_data  = ld;
        wb_pc_plus4 = pc;
        stall       = st;
        rs1_addr    = a1;
        rs2_addr    = a2;
    endtask

    function automatic logic [31:0] ref_read(input logic [4:0] a, input logic we,
                                             input logic [31:0] data);
        if (a == 0) return 32'd0;
        if (we && wb_inst[11:7] == a) return data;
        return mregs[a];
    endfunction

    task automatic check_outputs();
        logic we, known;
        logic [31:0] data;
        ref_wb(wb_inst, wb_alu_out, wb_ld_data, wb_pc_plus4, we, data, known);
        check_eq("wb_we", wb_we, we);
        check_eq("wb_rd", wb_rd, wb_inst[11:7]);
        if (known) check_eq("wb_data", wb_data, data);
        check_eq("rs1_data", rs1_data, ref_read(rs1_addr, we, data));
        check_eq("rs2_data", rs2_data, ref_read(rs2_addr, we, data));
        check_eq("instret", instret, minstret);
    endtask

    task automatic setup(input logic [31:0] inst, input logic [31:0] alu, input logic [31:0] ld,
                         input logic [14:0] pc, input logic st, input logic [4:0] a1,
                         input logic [4:0] a2);
        apply(inst, alu, ld, pc, st, a1, a2);
        #1;
        check_outputs();
    endtask

    task automatic tick();
        logic we, known;
        logic [31:0] data;
        @(posedge clk);
        ref_wb(wb_inst, wb_alu_out, wb_ld_data, wb_pc_plus4, we, data, known);
        if (!stall) begin
            if (we) mregs[wb_inst[11:7]] = data;
            if (wb_inst != 32'd0) minstret = minstret + 64'd1;
        end
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
        minstret = 64'd0;
    endtask

    logic [31:0] ld_insts [4] = '{32'h0000_0303, 32'h0000_4303, 32'h0000_1303, 32'h0000_2303};
    logic [31:0] ld_exps  [4] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_1280, 32'h1280_3456};
    logic [6:0]  opc_tab  [11] = '{7'h03, 7'h6F, 7'h67, 7'h33, 7'h13, 7'h37, 7'h17,
                                   7'h23, 7'h63, 7'h73, 7'h00};

    initial begin
        logic [63:0] base;
        logic [31:0] r, inst;
        logic [4:0]  rd, a1, a2;
        logic [2:0]  f3;
        logic [6:0]  opc;

        model_reset();
        rst = 1'b1;
        apply(32'd0, 32'd0, 32'd0, 15'd0, 1'b0, 5'd5, 5'd31);
        #3;
        check_eq("reset_instret", instret, 64'd0);
        check_eq("reset_rs1", rs1_data, 32'd0);
        check_eq("reset_rs2", rs2_data, 32'd0);
        #9 rst = 1'b0;

        // Write x5=10, then async reset mid-cycle.
        setup(32'h00A0_0293, 32'd10, 32'd0, 15'd0, 1'b0, 5'd5, 5'd0);
        tick();
        setup(32'd0, 32'd0, 32'd0, 15'd0, 1'b0, 5'd5, 5'd0);
        check_eq("x5_before_rst", rs1_data, 32'd10);
        rst = 1'b1;
        model_reset();
        #1;
        check_eq("rst_x5", rs1_data, 32'd0);
        check_eq("rst_instret", instret, 64'd0);
        check_outputs();
        rst = 1'b0;
        tick();

        // ADDI x5 bypass, then stored value with a bubble in WB.
        setup(32'h00A0_0293, 32'd10, 32'd0, 15'd0, 1'b0, 5'd5, 5'd0);
        check_eq("addi_bypass", rs1_data, 32'd10);
        tick();
        setup(32'd0, 32'd0, 32'd0, 15'd0, 1'b0, 5'd5, 5'd0);
        check_eq("addi_stored", rs1_data, 32'd10);
        check_eq("addi_instret", instret, 64'd1);
        tick();

        // Load alignment at offset 2.
        for (int i = 0; i < 4; i++) begin
            setup(ld_insts[i], 32'h0000_0002, 32'h1280_3456, 15'd0, 1'b0, 5'd6, 5'd0);
            check_eq("load_data", wb_data, {32'd0, ld_exps[i]});
            tick();
            setup(32'd0, 32'd0, 32'd0, 15'd0, 1'b0, 5'd6, 5'd0);
            check_eq("load_x6", rs1_data, {32'd0, ld_exps[i]});
            tick();
        end

        // JAL x1 writes pc+4.
        setup(32'h0000_00EF, 32'd0, 32'd0, 15'h0104, 1'b0, 5'd0, 5'd0);
        check_eq("jal_data", wb_data, 64'h104);
        check_eq("jal_rd", wb_rd, 64'd1);
        tick();
        setup(32'd0, 32'd0, 32'd0, 15'd0, 1'b0, 5'd1, 5'd0);
        check_eq("jal_x1", rs1_data, 64'h104);
        tick();

        // ADDI x7 held by stall for three cycles.
        base = minstret;
        for (int i = 0; i < 3; i++) begin
            setup(32'h0070_0393, 32'h77, 32'd0, 15'd0, 1'b1, 5'd0, 5'd7);
            check_eq("stall_bypass", rs2_data, 64'h77);
            check_eq("stall_instret", instret, base);
            tick();
        end
        setup(32'h0070_0393, 32'h77, 32'd0, 15'd0, 1'b0, 5'd0, 5'd7);
        tick();
        setup(32'd0, 32'd0, 32'd0, 15'd0, 1'b0, 5'd0, 5'd7);
        check_eq("stall_x7", rs2_data, 64'h77);
        check_eq("stall_count", instret, base + 64'd1);
        tick();
        setup(32'h0000_0013, 32'd5, 32'd0, 15'd0, 1'b0, 5'd0, 5'd0);
        check_eq("x0_we", wb_we, 64'd0);
        check_eq("x0_read", rs1_data, 64'd0);
        tick();

        // Store, branch, bubble: no writes, two retirements.
        base = minstret;
        setup(32'h0053_2423, 32'h1234, 32'd0, 15'd0, 1'b0, 5'd8, 5'd8);
        check_eq("sw_we", wb_we, 64'd0);
        tick();
        setup(32'h0000_0463, 32'h1234, 32'd0, 15'd0, 1'b0, 5'd8, 5'd8);
        check_eq("beq_we", wb_we, 64'd0);
        tick();
        setup(32'd0, 32'h1234, 32'd0, 15'd0, 1'b0, 5'd8, 5'd5);
        check_eq("bubble_we", wb_we, 64'd0);
        tick();
        setup(32'd0, 32'd0, 32'd0, 15'd0, 1'b0, 5'd5, 5'd8);
        check_eq("nonwrite_instret", instret, base + 64'd2);
        tick();

        for (int n = 0; n < 1500; n++) begin
            r   = $urandom();
            rd  = 5'($urandom_range(0, 31));
            f3  = 3'($urandom_range(0, 7));
            opc = opc_tab[$urandom_range(0, 10)];
            inst = (opc == 7'h00) ? 32'd0 : {r[31:15], f3, rd, opc};
            a1 = ($urandom_range(0, 2) == 0) ? rd : 5'($urandom_range(0, 31));
            a2 = ($urandom_range(0, 2) == 0) ? rd : 5'($urandom_range(0, 31));
            setup(inst, $urandom(), $urandom(), 15'($urandom_range(0, 32767)),
                  ($urandom_range(0, 3) == 0), a1, a2);
            if ($urandom_range(0, 99) == 0) begin
                rst = 1'b1;
                model_reset();
                #1;
                check_outputs();
                rst = 1'b0;
            end
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
